dc_download: RTL and testbench

DC_DOWNLOAD -- requirements
Module: dc_download

---
 rtl/dc_download_pkg.sv | 45 ++++
 rtl/dc_download_if.sv | 34 +++
 rtl/dc_download.sv | 97 +++++++++
 tb/tb_dc_download.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dc_download_pkg.sv
// Shared constants for the data-cache download assembler: command codes,
// flit control codes, FSM states and message lengths.
package dc_download_pkg;

    localparam int unsigned FLIT_W    = 16;
    localparam int unsigned MSG_FLITS = 9;
    localparam int unsigned MSG_W     = FLIT_W * MSG_FLITS;

    localparam logic [4:0] CMD_SHREP     = 5'b10000;
    localparam logic [4:0] CMD_EXREP     = 5'b10001;
    localparam logic [4:0] CMD_SHEXREP   = 5'b10010;
    localparam logic [4:0] CMD_WBREQ     = 5'b00100;
    localparam logic [4:0] CMD_INVREQ    = 5'b00101;
    localparam logic [4:0] CMD_FLUSHREQ  = 5'b00110;
    localparam logic [4:0] CMD_SCINVREQ  = 5'b00111;
    localparam logic [4:0] CMD_NACKREP   = 5'b10101;
    localparam logic [4:0] CMD_SCFLUREP  = 5'b10110;
    localparam logic [4:0] CMD_C2CINVREP = 5'b10111;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    localparam logic [3:0] LEN_1 = 4'd1;
    localparam logic [3:0] LEN_3 = 4'd3;
    localparam logic [3:0] LEN_9 = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RDY  = 2'b10
    } dc_state_e;

    // Unknown commands are treated as short (3-flit) requests.
    function automatic logic [3:0] msg_len(input logic [4:0] cmd);
        case (cmd)
            CMD_SHREP, CMD_EXREP, CMD_SHEXREP:              msg_len = LEN_9;
            CMD_WBREQ, CMD_INVREQ, CMD_FLUSHREQ, CMD_SCINVREQ: msg_len = LEN_3;
            CMD_NACKREP, CMD_SCFLUREP, CMD_C2CINVREP:       msg_len = LEN_1;
            default:                                        msg_len = LEN_3;
        endcase
    endfunction

endpackage

// File: rtl/dc_download_if.sv
// Flit-input / assembled-message-output bundle between the network
// download path (master) and the data-cache assembler (slave).
interface dc_download_if;
    import dc_download_pkg::*;

    logic [FLIT_W-1:0] IN_flit_dc;
    logic              v_IN_flit_dc;
    logic [1:0]        In_flit_ctrl_dc;
    logic              dc_done_access;
    logic              v_dc_download;
    logic [MSG_W-1:0]  dc_download_flits;
    logic [1:0]        dc_download_state;

    modport slave (
        input  IN_flit_dc,
        input  v_IN_flit_dc,
        input  In_flit_ctrl_dc,
        input  dc_done_access,
        output v_dc_download,
        output dc_download_flits,
        output dc_download_state
    );

    modport master (
        output IN_flit_dc,
        output v_IN_flit_dc,
        output In_flit_ctrl_dc,
        output dc_done_access,
        input  v_dc_download,
        input  dc_download_flits,
        input  dc_download_state
    );

endinterface

// File: rtl/dc_download.sv
// Assembles 1/3/9-flit messages into a 144-bit buffer for the data cache,
// holding the result until the cache acknowledges with dc_done_access.
module dc_download (
    input  logic          clk,
    input  logic          rst,
    dc_download_if.slave  dc_if
);
    import dc_download_pkg::*;

    dc_state_e         state_q, state_d;
    logic [3:0]        count_q;
    logic [3:0]        len_q;
    logic [MSG_W-1:0]  flits_q;
    logic              head_load;
    logic              body_store;
    logic [MSG_FLITS-1:1] slot_we;

    logic [FLIT_W-1:0] flit;
    logic [1:0]        ctrl;
    logic              flit_v;
    logic [3:0]        head_len;

    assign flit     = dc_if.IN_flit_dc;
    assign ctrl     = dc_if.In_flit_ctrl_dc;
    assign flit_v   = dc_if.v_IN_flit_dc;
    assign head_len = msg_len(flit[9:5]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        head_load  = 1'b0;
        body_store = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flit_v && ctrl == CTRL_HEAD) begin
                    head_load = 1'b1;
                    state_d   = (head_len == LEN_1) ? ST_RDY : ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A fresh head abandons the partial message and restarts.
                if (flit_v && ctrl == CTRL_HEAD) begin
                    head_load = 1'b1;
                    state_d   = (head_len == LEN_1) ? ST_RDY : ST_BUSY;
                end else if (flit_v && ctrl[1]) begin
                    body_store = 1'b1;
                    if (count_q + 4'd1 == len_q) begin
                        state_d = ST_RDY;
                    end
                end
            end
            ST_RDY: begin
                if (dc_if.dc_done_access) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 1; i < MSG_FLITS; i++) begin
            slot_we[i] = body_store && (count_q == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flits_q <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else if (head_load) begin
            flits_q <= {flit, {(MSG_W - FLIT_W){1'b0}}};
            count_q <= 4'd1;
            len_q   <= head_len;
        end else if (body_store) begin
            count_q <= count_q + 4'd1;
            for (int unsigned i = 1; i < MSG_FLITS; i++) begin
                if (slot_we[i]) begin
                    flits_q[MSG_W - 1 - FLIT_W * i -: FLIT_W] <= flit;
                end
            end
        end
    end

    assign dc_if.v_dc_download     = (state_q == ST_RDY);
    assign dc_if.dc_download_flits = flits_q;
    assign dc_if.dc_download_state = state_q;

endmodule

// File: tb/tb_dc_download.sv
// Directed bench for dc_download: 9/3/1-flit messages, handshake, abort,
// reset mid-message, gaps, early tail and the default command length.
module tb_dc_download;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [143:0] exp9;
    logic [143:0] exp3;
    logic [143:0] exp1;
    logic [143:0] expd;
    logic [143:0] held;

    dc_download_if dif ();

    dc_download u_dut (
        .clk   (clk),
        .rst   (rst),
        .dc_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1ns after the rising edge.
    task automatic step(input logic [15:0] f, input logic [1:0] c, input logic v, input logic d);
        @(negedge clk);
        dif.IN_flit_dc      = f;
        dif.In_flit_ctrl_dc = c;
        dif.v_IN_flit_dc    = v;
        dif.dc_done_access  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        dif.IN_flit_dc      = 16'h0000;
        dif.In_flit_ctrl_dc = 2'b00;
        dif.v_IN_flit_dc    = 1'b0;
        dif.dc_done_access  = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp9 = {16'h1234, {7{16'hAAAA}}, 16'h5555};
        exp3 = {16'h00A0, 16'hDEAD, 16'hBEEF, 96'h0};
        exp1 = {16'h02E0, 128'h0};
        expd = {16'h0001, 16'h1111, 16'h2222, 96'h0};

        rst = 1'b0;
        dif.IN_flit_dc      = 16'h0000;
        dif.In_flit_ctrl_dc = 2'b00;
        dif.v_IN_flit_dc    = 1'b0;
        dif.dc_done_access  = 1'b0;
        #3;
        check("reset_v", {143'h0, dif.v_dc_download}, 144'h0);
        check("reset_state", {142'h0, dif.dc_download_state}, 144'h0);
        check("reset_flits", dif.dc_download_flits, 144'h0);
        @(negedge clk);
        rst = 1'b1;

        // 9-flit exrep message
        step(16'h1234, 2'b01, 1'b1, 1'b0);
        step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        check("nine_mid_v", {143'h0, dif.v_dc_download}, 144'h0);
        check("nine_mid_state", {142'h0, dif.dc_download_state}, 144'h1);
        for (int k = 0; k < 4; k++) step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        check("nine_pre_tail_state", {142'h0, dif.dc_download_state}, 144'h1);
        step(16'h5555, 2'b11, 1'b1, 1'b0);
        check("nine_v", {143'h0, dif.v_dc_download}, 144'h1);
        check("nine_state", {142'h0, dif.dc_download_state}, 144'h2);
        check("nine_flits", dif.dc_download_flits, exp9);

        // Hold in RDY with traffic, then simultaneous done + head
        step(16'h02E0, 2'b01, 1'b1, 1'b0);
        check("rdy_hold1", dif.dc_download_flits, exp9);
        step(16'hBBBB, 2'b10, 1'b1, 1'b0);
        check("rdy_hold2", dif.dc_download_flits, exp9);
        step(16'hCCCC, 2'b11, 1'b1, 1'b0);
        check("rdy_hold3", dif.dc_download_flits, exp9);
        check("rdy_hold_v", {143'h0, dif.v_dc_download}, 144'h1);
        step(16'h02E0, 2'b01, 1'b1, 1'b1);
        check("done_v", {143'h0, dif.v_dc_download}, 144'h0);
        check("done_state", {142'h0, dif.dc_download_state}, 144'h0);
        check("done_flits_kept", dif.dc_download_flits, exp9);

        // IDLE ignores non-head flits and stray done
        step(16'hBBBB, 2'b10, 1'b1, 1'b1);
        check("idle_ignore_state", {142'h0, dif.dc_download_state}, 144'h0);
        check("idle_ignore_flits", dif.dc_download_flits, exp9);

        // 3-flit message
        step(16'h00A0, 2'b01, 1'b1, 1'b0);
        step(16'hDEAD, 2'b10, 1'b1, 1'b1);
        check("three_mid_v", {143'h0, dif.v_dc_download}, 144'h0);
        check("three_mid_state", {142'h0, dif.dc_download_state}, 144'h1);
        step(16'hBEEF, 2'b11, 1'b1, 1'b0);
        check("three_v", {143'h0, dif.v_dc_download}, 144'h1);
        check("three_flits", dif.dc_download_flits, exp3);
        step(16'h0000, 2'b00, 1'b0, 1'b1);
        check("three_done_state", {142'h0, dif.dc_download_state}, 144'h0);

        // 1-flit message
        step(16'h02E0, 2'b01, 1'b1, 1'b0);
        check("one_v", {143'h0, dif.v_dc_download}, 144'h1);
        check("one_state", {142'h0, dif.dc_download_state}, 144'h2);
        check("one_flits", dif.dc_download_flits, exp1);
        step(16'h0000, 2'b00, 1'b0, 1'b1);

        // Abort 9-flit message with a 1-flit head
        step(16'h1234, 2'b01, 1'b1, 1'b0);
        step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        step(16'h02E0, 2'b01, 1'b1, 1'b0);
        check("abort_state", {142'h0, dif.dc_download_state}, 144'h2);
        check("abort_flits", dif.dc_download_flits, exp1);
        step(16'h0000, 2'b00, 1'b0, 1'b1);

        // Gaps, ctrl-00 valid flits and an early tail inside a 9-flit message
        step(16'h1234, 2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(16'hFFFF, 2'b10, 1'b0, 1'b0);
            step(16'hEEEE, 2'b00, 1'b1, 1'b0);
            step(16'hAAAA, (k == 1) ? 2'b11 : 2'b10, 1'b1, 1'b0);
        end
        check("gap_busy_state", {142'h0, dif.dc_download_state}, 144'h1);
        step(16'h7777, 2'b10, 1'b0, 1'b0);
        step(16'h5555, 2'b11, 1'b1, 1'b0);
        check("gap_v", {143'h0, dif.v_dc_download}, 144'h1);
        check("gap_flits", dif.dc_download_flits, exp9);
        step(16'h0000, 2'b00, 1'b0, 1'b1);

        // Unknown command defaults to 3 flits
        step(16'h0001, 2'b01, 1'b1, 1'b0);
        step(16'h1111, 2'b10, 1'b1, 1'b0);
        check("dflt_mid_state", {142'h0, dif.dc_download_state}, 144'h1);
        step(16'h2222, 2'b11, 1'b1, 1'b0);
        check("dflt_state", {142'h0, dif.dc_download_state}, 144'h2);
        check("dflt_flits", dif.dc_download_flits, expd);
        step(16'h0000, 2'b00, 1'b0, 1'b1);

        // Asynchronous reset after 5 flits
        step(16'h1234, 2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        held = dif.dc_download_flits;
        check("prereset_flits", held, {16'h1234, {4{16'hAAAA}}, 64'h0});
        #2;
        rst = 1'b0;
        #1;
        check("areset_v", {143'h0, dif.v_dc_download}, 144'h0);
        check("areset_state", {142'h0, dif.dc_download_state}, 144'h0);
        check("areset_flits", dif.dc_download_flits, 144'h0);
        @(negedge clk);
        rst = 1'b1;
        step(16'hAAAA, 2'b10, 1'b1, 1'b0);
        check("post_reset_body_ignored", {142'h0, dif.dc_download_state}, 144'h0);
        step(16'h02E0, 2'b01, 1'b1, 1'b0);
        check("post_reset_head", dif.dc_download_flits, exp1);
        check("post_reset_v", {143'h0, dif.v_dc_download}, 144'h1);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
